// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2,
    S_DROP = 2'd3
  } fetch_state_t;

  localparam logic [31:0] PC_STEP         = 32'd4;
  localparam logic [31:0] PC_R15_OFS      = 32'd8;
  localparam logic [31:0] WORD_ALIGN_MASK = 32'hFFFF_FFFC;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & WORD_ALIGN_MASK;
  endfunction

endpackage

// File: rtl/fetch_perf.sv
// Fetch performance counters: accepted instructions, stall cycles, flushes.
// Only present when FETCH_PERF_CNT_EN is defined.
`ifdef FETCH_PERF_CNT_EN
module fetch_perf (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_accept,
  input  logic        i_stall,
  input  logic        i_flush,
  output logic [31:0] o_fetched,
  output logic [31:0] o_stall,
  output logic [15:0] o_flush
);

  logic [31:0] r_fetched;
  logic [31:0] r_stall;
  logic [15:0] r_flush;

  // Free-running event counters; all wrap silently on overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_fetched <= 32'd0;
      r_stall   <= 32'd0;
      r_flush   <= 16'd0;
    end else begin
      if (i_accept) r_fetched <= r_fetched + 32'd1;
      if (i_stall)  r_stall   <= r_stall + 32'd1;
      if (i_flush)  r_flush   <= r_flush + 16'd1;
    end
  end

  assign o_fetched = r_fetched;
  assign o_stall   = r_stall;
  assign o_flush   = r_flush;

endmodule
`endif

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, one outstanding imem request, holds the
// fetched word for decode. Define FETCH_PERF_CNT_EN to add perf counter outputs.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] Instr,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        PCSrc,
  input  logic [31:0] branch_target,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus8
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stall,
  output logic [15:0] perf_flush
`endif
);

  fetch_state_t r_state;
  fetch_state_t w_state_nxt;
  logic [31:0]  r_pc;
  logic [31:0]  w_pc_nxt;
  logic         w_capture;
  logic [31:0]  r_instr;
  logic [31:0]  r_pc_out;
  logic [31:0]  r_pc_plus8;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_REQ;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and next-PC; flush outranks every other event in every state.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_capture   = 1'b0;
    case (r_state)
      S_REQ: begin
        if (flush) begin
          w_pc_nxt    = word_align(flush_pc);
          w_state_nxt = imem_gnt ? S_DROP : S_REQ;
        end else if (imem_gnt) begin
          w_state_nxt = S_WAIT;
        end else begin
          w_state_nxt = S_REQ;
        end
      end
      S_WAIT: begin
        if (flush) begin
          w_pc_nxt    = word_align(flush_pc);
          w_state_nxt = imem_rvalid ? S_REQ : S_DROP;
        end else if (imem_rvalid) begin
          w_capture   = 1'b1;
          w_state_nxt = S_HOLD;
        end else begin
          w_state_nxt = S_WAIT;
        end
      end
      S_HOLD: begin
        if (flush) begin
          w_pc_nxt    = word_align(flush_pc);
          w_state_nxt = S_REQ;
        end else if (instr_ready) begin
          w_pc_nxt    = PCSrc ? word_align(branch_target) : (r_pc + PC_STEP);
          w_state_nxt = S_REQ;
        end else begin
          w_state_nxt = S_HOLD;
        end
      end
      S_DROP: begin
        // Response of the discarded request is swallowed here.
        if (flush) begin
          w_pc_nxt    = word_align(flush_pc);
          w_state_nxt = imem_rvalid ? S_REQ : S_DROP;
        end else if (imem_rvalid) begin
          w_state_nxt = S_REQ;
        end else begin
          w_state_nxt = S_DROP;
        end
      end
      default: begin
        w_state_nxt = S_REQ;
      end
    endcase
  end

  // PC and held-instruction registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc       <= RESET_PC;
      r_instr    <= 32'd0;
      r_pc_out   <= RESET_PC;
      r_pc_plus8 <= RESET_PC + PC_R15_OFS;
    end else begin
      r_pc <= w_pc_nxt;
      if (w_capture) begin
        r_instr    <= imem_rdata;
        r_pc_out   <= r_pc;
        r_pc_plus8 <= r_pc + PC_R15_OFS;
      end
    end
  end

  assign imem_req    = (r_state == S_REQ) && !reset;
  assign imem_addr   = r_pc;
  assign instr_valid = (r_state == S_HOLD);
  assign Instr       = r_instr;
  assign pc_out      = r_pc_out;
  assign pc_plus8    = r_pc_plus8;

`ifdef FETCH_PERF_CNT_EN
  logic w_accept;
  logic w_stall;
  logic w_flush_evt;

  assign w_accept    = (r_state == S_HOLD) && instr_ready && !flush;
  assign w_stall     = (r_state != S_HOLD);
  assign w_flush_evt = flush;

  fetch_perf u_perf (
    .clk       (clk),
    .reset     (reset),
    .i_accept  (w_accept),
    .i_stall   (w_stall),
    .i_flush   (w_flush_evt),
    .o_fetched (perf_fetched),
    .o_stall   (perf_stall),
    .o_flush   (perf_flush)
  );
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: memory responder, PC-level reference
// model with per-cycle compare, and directed scenarios with literal expectations.
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam logic [31:0] ALIGN  = 32'hFFFF_FFFC;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] Instr;
  logic        instr_valid;
  logic        instr_ready;
  logic        PCSrc;
  logic [31:0] branch_target;
  logic        flush;
  logic [31:0] flush_pc;
  logic [31:0] pc_out;
  logic [31:0] pc_plus8;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_stall;
  logic [15:0] perf_flush;
`endif

  int checks = 0;
  int failures = 0;

  // memory responder configuration (written by stimulus only)
  int gnt_delay = 0;
  int rv_delay = 1;
  logic poison_arm = 1'b0;

  // reference model state (written by monitor only)
  logic [31:0] exp_pc = RST_PC;
  logic        armed = 1'b0;
  logic        prev_flush = 1'b0;
  int          gnt_count = 0;
  logic [31:0] last_gnt_addr = 32'd0;
  int          n_accept = 0;
  int          n_stall = 0;
  int          n_flush = 0;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk           (clk),
    .reset         (reset),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_gnt      (imem_gnt),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .Instr         (Instr),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .PCSrc         (PCSrc),
    .branch_target (branch_target),
    .flush         (flush),
    .flush_pc      (flush_pc),
    .pc_out        (pc_out),
    .pc_plus8      (pc_plus8)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetched  (perf_fetched),
    .perf_stall    (perf_stall),
    .perf_flush    (perf_flush)
`endif
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Instruction memory: grants after gnt_delay request cycles, answers rv_delay cycles later.
  initial begin : responder
    logic        pend;
    int          pend_cnt;
    logic [31:0] pend_addr;
    logic        pend_poison;
    logic        poison_done;
    int          req_wait;
    pend = 1'b0; pend_cnt = 0; pend_addr = 32'd0; pend_poison = 1'b0;
    poison_done = 1'b0; req_wait = 0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'd0;
    forever begin
      @(negedge clk);
      imem_gnt = 1'b0;
      imem_rvalid = 1'b0;
      if (pend) begin
        pend_cnt--;
        if (pend_cnt <= 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = pend_poison ? 32'hDEAD_BEEF : mem_word(pend_addr);
          pend = 1'b0;
        end
      end else if (imem_req) begin
        if (req_wait >= gnt_delay) begin
          imem_gnt    = 1'b1;
          pend        = 1'b1;
          pend_cnt    = rv_delay;
          pend_addr   = imem_addr;
          pend_poison = poison_arm && !poison_done;
          if (pend_poison) poison_done = 1'b1;
          req_wait    = 0;
        end else begin
          req_wait++;
        end
      end
    end
  end

  // Reference model + per-cycle compare, evaluated just before each rising edge.
  initial begin : monitor
    forever begin
      @(negedge clk);
      #4;
      if (reset) begin
        exp_pc = RST_PC; armed = 1'b1; prev_flush = 1'b0;
        n_accept = 0; n_stall = 0; n_flush = 0;
      end else if (armed) begin
        if (prev_flush) chk("valid_after_flush", 32'(instr_valid), 32'd0);
        if (imem_req) begin
          chk("imem_addr", imem_addr, exp_pc);
          if (imem_gnt) begin
            gnt_count++;
            last_gnt_addr = imem_addr;
          end
        end
        if (instr_valid) begin
          chk("pc_out", pc_out, exp_pc);
          chk("Instr", Instr, mem_word(exp_pc));
          chk("pc_plus8", pc_plus8, exp_pc + 32'd8);
          chk("req_while_hold", 32'(imem_req), 32'd0);
        end else begin
          n_stall++;
        end
        if (flush) begin
          exp_pc = flush_pc & ALIGN;
          n_flush++;
        end else if (instr_valid && instr_ready) begin
          n_accept++;
          exp_pc = PCSrc ? (branch_target & ALIGN) : (exp_pc + 32'd4);
        end
        prev_flush = flush;
      end
    end
  end

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    while (!instr_valid && n < 60) begin
      @(negedge clk); #1;
      n++;
    end
    chk(name, 32'(instr_valid), 32'd1);
  endtask

  task automatic accept_one(input logic src, input logic [31:0] bt,
                            output logic [31:0] cap_pc, output logic [31:0] cap_p8,
                            output logic [31:0] cap_instr);
    wait_valid("wait_valid");
    cap_pc = pc_out; cap_p8 = pc_plus8; cap_instr = Instr;
    instr_ready = 1'b1; PCSrc = src; branch_target = bt;
    @(negedge clk); #1;
    instr_ready = 1'b0; PCSrc = 1'b0;
  endtask

  task automatic wait_grant(output logic [31:0] a);
    int start;
    int n;
    start = gnt_count; n = 0;
    while (gnt_count == start && n < 60) begin
      @(negedge clk); #1;
      n++;
    end
    chk("grant_seen", 32'(gnt_count != start), 32'd1);
    a = last_gnt_addr;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [31:0] p, p8, ins, ga;
    int hold_ok;
    reset = 1'b1; instr_ready = 1'b0; PCSrc = 1'b0; branch_target = 32'd0;
    flush = 1'b0; flush_pc = 32'd0;
    repeat (2) @(negedge clk);
    #1;
    chk("req_in_reset", 32'(imem_req), 32'd0);
    reset = 1'b0;
    #1;
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_pc_out", pc_out, 32'h0000_0100);
    chk("rst_pc_plus8", pc_plus8, 32'h0000_0108);
    chk("rst_instr", Instr, 32'd0);
    chk("rst_addr", imem_addr, 32'h0000_0100);
    chk("rst_req", 32'(imem_req), 32'd1);

    // sequential fetch, zero-wait memory
    accept_one(1'b0, 32'd0, p, p8, ins);
    chk("seq0_pc", p, 32'h0000_0100);
    chk("seq0_p8", p8, 32'h0000_0108);
    chk("seq0_instr", ins, 32'h1257_6520);
    accept_one(1'b0, 32'd0, p, p8, ins);
    chk("seq1_pc", p, 32'h0000_0104);
    accept_one(1'b0, 32'd0, p, p8, ins);
    chk("seq2_pc", p, 32'h0000_0108);

    // taken branch to unaligned target
    accept_one(1'b1, 32'h0000_0203, p, p8, ins);
    chk("br_from_pc", p, 32'h0000_010C);
    wait_grant(ga);
    chk("br_addr", ga, 32'h0000_0200);

    // consumer stalls five cycles
    wait_valid("hold_valid");
    p = pc_out; ins = Instr;
    hold_ok = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      if (instr_valid && !imem_req && pc_out == p && Instr == ins) hold_ok++;
    end
    chk("hold_stable_cycles", 32'(hold_ok), 32'd5);

    // flush one cycle after grant; the late response is poisoned
    rv_delay = 4; poison_arm = 1'b1;
    accept_one(1'b0, 32'd0, p, p8, ins);
    wait_grant(ga);
    chk("pre_flush_addr", ga, 32'h0000_0204);
    flush = 1'b1; flush_pc = 32'h0000_001A;
    @(negedge clk); #1;
    flush = 1'b0; rv_delay = 1;
    chk("flush_valid0", 32'(instr_valid), 32'd0);
    wait_grant(ga);
    chk("flush_addr", ga, 32'h0000_0018);
    accept_one(1'b1, 32'hFFFF_FFFE, p, p8, ins);
    chk("flush_pc_out", p, 32'h0000_0018);

    // PC wrap at top of address space
    wait_grant(ga);
    chk("top_addr", ga, 32'hFFFF_FFFC);
    accept_one(1'b0, 32'd0, p, p8, ins);
    chk("top_p8_wrap", p8, 32'h0000_0004);
    wait_grant(ga);
    chk("wrap_addr", ga, 32'h0000_0000);

    // one-cycle grant delay, then flush while holding (overrides ready/PCSrc)
    gnt_delay = 1;
    for (int i = 0; i < 3; i++) accept_one(1'b0, 32'd0, p, p8, ins);
    chk("gd1_pc", p, 32'h0000_0008);
    wait_valid("hold_flush_valid");
    flush = 1'b1; flush_pc = 32'h0000_0043;
    instr_ready = 1'b1; PCSrc = 1'b1; branch_target = 32'h0000_0300;
    @(negedge clk); #1;
    flush = 1'b0; instr_ready = 1'b0; PCSrc = 1'b0;
    chk("hold_flush_valid0", 32'(instr_valid), 32'd0);
    wait_grant(ga);
    chk("hold_flush_addr", ga, 32'h0000_0040);

    // flush while request is still waiting for grant
    gnt_delay = 2;
    accept_one(1'b0, 32'd0, p, p8, ins);
    flush = 1'b1; flush_pc = 32'h0000_0080;
    @(negedge clk); #1;
    flush = 1'b0;
    wait_grant(ga);
    chk("req_flush_addr", ga, 32'h0000_0080);
    accept_one(1'b0, 32'd0, p, p8, ins);
    chk("req_flush_pc", p, 32'h0000_0080);

`ifdef FETCH_PERF_CNT_EN
    chk("perf_fetched", perf_fetched, 32'(n_accept));
    chk("perf_stall", perf_stall, 32'(n_stall));
    chk("perf_flush", 32'(perf_flush), 32'(n_flush));
    chk("perf_flush_lit", 32'(perf_flush), 32'd3);
`endif

    // reset while a fetch is outstanding; orphaned response must be ignored
    gnt_delay = 0; rv_delay = 3;
    wait_grant(ga);
    reset = 1'b1;
    @(negedge clk); #1;
    reset = 1'b0;
    accept_one(1'b0, 32'd0, p, p8, ins);
    chk("post_rst_pc", p, 32'h0000_0100);
    chk("post_rst_instr", ins, 32'h1257_6520);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
